// File: rtl/micro_pkg.sv
// Shared types for the micro decoder link: command encoding, decoder code map
// and the issuer FSM states.
package micro_pkg;

    typedef enum logic [1:0] {
        CMD_A   = 2'd0,
        CMD_L   = 2'd1,
        CMD_B   = 2'd2,
        CMD_NOP = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [3:0] CODE_A    = 4'b0011;
    localparam logic [3:0] CODE_L    = 4'b1010;
    localparam logic [3:0] CODE_B    = 4'b1011;
    localparam logic [3:0] IDLE_CODE = 4'b1111;

    function automatic logic [3:0] cmd_to_code(input cmd_e cmd);
        logic [3:0] code;
        case (cmd)
            CMD_A:   code = CODE_A;
            CMD_L:   code = CODE_L;
            CMD_B:   code = CODE_B;
            default: code = IDLE_CODE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/micro_issuer_fifo.sv
// Small synchronous request FIFO (2-bit entries) with occupancy count and an
// optional single-cycle flush; pointers wrap modulo DEPTH (power of two).
module micro_issuer_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [1:0]               i_push_data,
    input  logic                     i_pop,
    output logic [1:0]               o_pop_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign o_full     = (count_q == (AW+1)'(DEPTH));
    assign o_empty    = (count_q == '0);
    assign o_count    = count_q;
    assign o_pop_data = mem_q[rd_ptr_q];

    assign do_push = i_push && !o_full && !i_flush;
    assign do_pop  = i_pop && !o_empty && !i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_push_data;
    end

endmodule

// File: rtl/micro_code_issuer.sv
// Queues command requests and presents each as a stable 4-bit code with o_en
// high for HOLD_CYCLES, followed by GAP_CYCLES idle. Optional: MICRO_ISSUER_FLUSH_EN.
module micro_code_issuer
    import micro_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
`ifdef MICRO_ISSUER_FLUSH_EN
    input  logic                    i_flush,
`endif
    input  logic                    i_req_valid,
    input  logic [1:0]              i_req_cmd,
    output logic                    o_req_ready,
    output logic                    o_en,
    output logic [3:0]              o_code,
    output logic                    o_busy,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Handshake: a request transfers on any cycle with i_req_valid && o_req_ready;
    // ready reflects occupancy before this cycle's pop, so a full FIFO refuses
    // even when a pop happens in the same cycle. The requester holds valid/cmd.

    logic          flush;
    logic          push;
    logic          pop;
    logic [1:0]    pop_data;
    logic          fifo_full;
    logic          fifo_empty;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    cmd_e          cmd_q, cmd_d;
    logic          en_q, en_d;
    logic [3:0]    code_q, code_d;

`ifdef MICRO_ISSUER_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    assign o_req_ready = !fifo_full && !flush;
    assign push        = i_req_valid && o_req_ready;
    assign o_busy      = (state_q != IDLE) || !fifo_empty;
    assign o_en        = en_q;
    assign o_code      = code_q;

    micro_issuer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (flush),
        .i_push      (push),
        .i_push_data (i_req_cmd),
        .i_pop       (pop),
        .o_pop_data  (pop_data),
        .o_count     (o_count),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cmd_d   = cmd_e'(pop_data);
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(GAP_CYCLES - 1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush abandons the current command and restarts a full gap; an idle
        // issuer with nothing queued is left untouched.
        if (flush && ((state_q != IDLE) || !fifo_empty)) begin
            pop     = 1'b0;
            cnt_d   = CW'(GAP_CYCLES - 1);
            state_d = GAP;
        end

        // NOP keeps the DRIVE timing but shows the idle code with enable low.
        en_d   = (state_d == DRIVE) && (cmd_d != CMD_NOP);
        code_d = en_d ? cmd_to_code(cmd_d) : IDLE_CODE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= CMD_NOP;
            en_q    <= 1'b0;
            code_q  <= IDLE_CODE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            en_q    <= en_d;
            code_q  <= code_d;
        end
    end

endmodule

// File: tb/tb_micro_code_issuer.sv
// Directed bench for micro_code_issuer: driver tasks push requests and queue the
// expected code windows; a negedge monitor checks every window as it appears.
module tb_micro_code_issuer;

    localparam int HOLD = 8;
    localparam int GAP  = 2;
    localparam int PER  = HOLD + GAP + 1;

    typedef struct {
        logic [3:0] code;
        int         start;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       req_valid;
    logic [1:0] req_cmd;
    logic       req_ready;
    logic       en;
    logic [3:0] code;
    logic       busy;
    logic [2:0] count;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_start = -100;
    exp_t exp_q[$];
    bit   in_win = 0;
    int   win_len = 0;
    logic [3:0] win_code = 4'hF;

    micro_code_issuer #(
        .DEPTH       (4),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
`ifdef MICRO_ISSUER_FLUSH_EN
        .i_flush     (flush),
`endif
        .i_req_valid (req_valid),
        .i_req_cmd   (req_cmd),
        .o_req_ready (req_ready),
        .o_en        (en),
        .o_code      (code),
        .o_busy      (busy),
        .o_count     (count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, got, got, want, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    // Expected window start: two cycles after acceptance, but never sooner
    // than one full period after the previous command's window.
    task automatic push(input logic [1:0] cmd, input logic [3:0] want_code);
        int  a;
        int  k;
        int  s;
        bit  acc;
        acc = 0;
        a   = cyc;
        k   = 0;
        req_valid = 1'b1;
        req_cmd   = cmd;
        while (!acc && k < 200) begin
            a   = cyc;
            acc = req_ready;
            step();
            k++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            chk("push_timeout", 0, 1);
        end else begin
            s = (a + 2 > last_start + PER) ? a + 2 : last_start + PER;
            last_start = s;
            if (cmd != 2'd3) exp_q.push_back('{code: want_code, start: s});
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0 || in_win) && k < 400) begin
            step();
            k++;
        end
        chk("drain_pending", exp_q.size(), 0);
        chk("drain_busy", int'(busy), 0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            in_win  = 0;
            win_len = 0;
        end else if (en) begin
            if (!in_win) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_window", int'(code), 15);
                end else begin
                    e = exp_q.pop_front();
                    chk("window_code", int'(code), int'(e.code));
                    chk("window_start", cyc, e.start);
                    win_code = e.code;
                end
                in_win  = 1;
                win_len = 1;
            end else begin
                win_len++;
                if (code != win_code) chk("code_stable", int'(code), int'(win_code));
            end
        end else begin
            if (in_win) chk("window_len", win_len, HOLD);
            in_win  = 0;
            win_len = 0;
            if (code != 4'hF) chk("idle_code", int'(code), 15);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int a;
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b1;
        req_cmd   = 2'd0;
        #1;
        repeat (3) step();
        chk("rst_en", int'(en), 0);
        chk("rst_code", int'(code), 15);
        chk("rst_count", int'(count), 0);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (4) step();
        chk("post_rst_count", int'(count), 0);
        chk("post_rst_busy", int'(busy), 0);

        // Single L command: window a+2..a+9, gap a+10..a+11, idle at a+12.
        a = cyc;
        push(2'd1, 4'b1010);
        wait_until(a + 2);
        chk("single_en_rise", int'(en), 1);
        wait_until(a + 11);
        chk("single_busy_gap", int'(busy), 1);
        chk("single_en_gap", int'(en), 0);
        step();
        chk("single_busy_idle", int'(busy), 0);
        wait_idle();

        // Back-to-back A, B, NOP, L.
        push(2'd0, 4'b0011);
        push(2'd2, 4'b1011);
        push(2'd3, 4'b1111);
        push(2'd1, 4'b1010);
        chk("b2b_count_peak", int'(count), 3);
        wait_idle();

        // Full FIFO with one request held until a pop frees a slot.
        a = cyc;
        push(2'd0, 4'b0011);
        wait_until(a + 3);
        push(2'd2, 4'b1011);
        push(2'd1, 4'b1010);
        push(2'd2, 4'b1011);
        push(2'd0, 4'b0011);
        chk("full_count", int'(count), 4);
        chk("full_ready", int'(req_ready), 0);
        push(2'd1, 4'b1010);
        chk("full_refill_count", int'(count), 4);
        push(2'd3, 4'b1111);
        wait_idle();

        // Reset on the 4th DRIVE cycle with two commands queued.
        a = cyc;
        push(2'd0, 4'b0011);
        push(2'd2, 4'b1011);
        push(2'd1, 4'b1010);
        chk("rst_mid_queued", int'(count), 2);
        wait_until(a + 5);
        chk("rst_mid_driving", int'(en), 1);
        rst_n = 1'b0;
        step();
        chk("rst_mid_en", int'(en), 0);
        chk("rst_mid_count", int'(count), 0);
        chk("rst_mid_code", int'(code), 15);
        chk("rst_mid_ready", int'(req_ready), 1);
        rst_n = 1'b1;
        exp_q.delete();
        last_start = -100;
        repeat (30) step();
        chk("rst_mid_no_more", int'(busy), 0);

`ifdef MICRO_ISSUER_FLUSH_EN
        // Flush during DRIVE with three queued: full gap, then idle.
        a = cyc;
        push(2'd0, 4'b0011);
        push(2'd2, 4'b1011);
        push(2'd1, 4'b1010);
        push(2'd2, 4'b1011);
        chk("flush_queued", int'(count), 3);
        flush = 1'b1;
        chk("flush_ready", int'(req_ready), 0);
        step();
        flush = 1'b0;
        exp_q.delete();
        last_start = -100;
        chk("flush_en", int'(en), 0);
        chk("flush_count", int'(count), 0);
        chk("flush_busy_gap0", int'(busy), 1);
        step();
        chk("flush_busy_gap1", int'(busy), 1);
        step();
        chk("flush_busy_idle", int'(busy), 0);
        repeat (20) step();
        chk("flush_no_more", int'(busy), 0);
`endif

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
